// File: rtl/divfp_iterative_if.sv
// Handshake bundle for the iterative FP divider: operand request and result response.
interface divfp_iterative_if #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned MANT_W = 10
);
  localparam int unsigned W = 1 + EXP_W + MANT_W;

  logic         i_Valid;
  logic         o_Ready;
  logic [W-1:0] i_Dividend;
  logic [W-1:0] i_Divisor;
  logic         o_Valid;
  logic         i_Ready;
  logic [W-1:0] o_Quotient;
  logic [3:0]   o_Flags;
  logic         o_Exception;

  modport slave (
    input  i_Valid, i_Dividend, i_Divisor, i_Ready,
    output o_Ready, o_Valid, o_Quotient, o_Flags, o_Exception
  );

  modport master (
    output i_Valid, i_Dividend, i_Divisor, i_Ready,
    input  o_Ready, o_Valid, o_Quotient, o_Flags, o_Exception
  );
endinterface

// File: rtl/divfp_iterative.sv
// Multi-cycle IEEE-754-style divider: radix-2 restoring quotient, one bit per clock,
// round-to-nearest-even, subnormals flushed to zero.
module divfp_iterative #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned MANT_W = 10
) (
  input  logic               i_Clock,
  input  logic               i_Reset_n,
  divfp_iterative_if.slave   bus
);
  localparam int unsigned W     = 1 + EXP_W + MANT_W;
  localparam int unsigned QBITS = MANT_W + 3;
  localparam int unsigned MW    = MANT_W + 1;
  localparam int unsigned RW    = MANT_W + 2;
  localparam int unsigned FW    = MANT_W + 1;
  localparam int unsigned EW    = EXP_W + 2;
  localparam int unsigned CW    = $clog2(QBITS);
  localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic signed [EW-1:0]    E_MAX    = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [RW-1:0]           rem_q, rem_d;
  logic [QBITS-1:0]        quo_q, quo_d;
  logic [MW-1:0]           mb_q, mb_d;
  logic                    sign_q, sign_d;
  logic signed [EW-1:0]    exp_q, exp_d;
  logic [W-1:0]            result_q, result_d;
  logic [3:0]              flags_q, flags_d;
  logic                    exc_q, exc_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;

  // Operand field decode
  logic                sa, sb;
  logic [EXP_W-1:0]    ea, eb;
  logic [MANT_W-1:0]   fa, fb;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, invalid;

  assign sa = bus.i_Dividend[W-1];
  assign sb = bus.i_Divisor[W-1];
  assign ea = bus.i_Dividend[W-2 -: EXP_W];
  assign eb = bus.i_Divisor[W-2 -: EXP_W];
  assign fa = bus.i_Dividend[MANT_W-1:0];
  assign fb = bus.i_Divisor[MANT_W-1:0];

  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_inf   = (ea == EXP_ONES) && (fa == '0);
  assign b_inf   = (eb == EXP_ONES) && (fb == '0);
  assign a_nan   = (ea == EXP_ONES) && (fa != '0);
  assign b_nan   = (eb == EXP_ONES) && (fb != '0);
  assign invalid = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);

  // One restoring step; the partial remainder stays below Mb so its MSB drops on the shift
  logic          q_bit;
  logic [RW-2:0] rem_nx;

  always_comb begin
    q_bit  = (rem_q >= RW'(mb_q));
    rem_nx = q_bit ? (RW-1)'(rem_q - RW'(mb_q)) : rem_q[RW-2:0];
  end

  // Normalise and round the finished quotient
  logic [MANT_W-1:0]    frac_raw;
  logic                 guard, sticky;
  logic [FW-1:0]        frac_inc;
  logic signed [EW-1:0] e_rnd;
  logic [W-1:0]         rnd_result;
  logic [3:0]           rnd_flags;

  always_comb begin
    if (quo_q[QBITS-1]) begin
      frac_raw = quo_q[QBITS-2:2];
      guard    = quo_q[1];
      sticky   = quo_q[0] | (|rem_q);
      e_rnd    = exp_q;
    end else begin
      frac_raw = quo_q[QBITS-3:1];
      guard    = quo_q[0];
      sticky   = |rem_q;
      e_rnd    = exp_q - EW'(1);
    end
    frac_inc = {1'b0, frac_raw} + FW'(guard & (sticky | frac_raw[0]));
    if (frac_inc[MANT_W]) e_rnd = e_rnd + EW'(1);

    if (!e_rnd[EW-1] && (e_rnd >= E_MAX)) begin
      rnd_result = {sign_q, EXP_ONES, MANT_W'(0)};
      rnd_flags  = 4'b0010;
    end else if (e_rnd[EW-1] || (e_rnd == '0)) begin
      rnd_result = {sign_q, (W-1)'(0)};
      rnd_flags  = 4'b0001;
    end else begin
      rnd_result = {sign_q, e_rnd[EXP_W-1:0], frac_inc[MANT_W-1:0]};
      rnd_flags  = 4'b0000;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      mb_q     <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      exc_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      mb_q     <= mb_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      exc_q    <= exc_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    mb_d     = mb_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    result_d = result_q;
    flags_d  = flags_q;
    exc_d    = exc_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_Valid) begin
          sign_d = sa ^ sb;
          if (invalid) begin
            result_d = {1'b0, EXP_ONES, 1'b1, (MANT_W-1)'(0)};
            flags_d  = 4'b1000;
            exc_d    = 1'b1;
            state_d  = DONE;
          end else if (a_inf) begin
            result_d = {sa ^ sb, EXP_ONES, MANT_W'(0)};
            flags_d  = 4'b0000;
            exc_d    = 1'b0;
            state_d  = DONE;
          end else if (b_zero) begin
            result_d = {sa ^ sb, EXP_ONES, MANT_W'(0)};
            flags_d  = 4'b0100;
            exc_d    = 1'b1;
            state_d  = DONE;
          end else if (a_zero || b_inf) begin
            result_d = {sa ^ sb, (W-1)'(0)};
            flags_d  = 4'b0000;
            exc_d    = 1'b0;
            state_d  = DONE;
          end else begin
            rem_d   = RW'({1'b1, fa});
            mb_d    = {1'b1, fb};
            quo_d   = '0;
            cnt_d   = '0;
            exp_d   = EW'(ea) - EW'(eb) + EW'(BIAS);
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        quo_d = {quo_q[QBITS-2:0], q_bit};
        rem_d = {rem_nx, 1'b0};
        if (cnt_q == CW'(QBITS - 1)) begin
          cnt_d   = '0;
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ROUND: begin
        result_d = rnd_result;
        flags_d  = rnd_flags;
        exc_d    = 1'b0;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.i_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  assign bus.o_Ready     = ready_q;
  assign bus.o_Valid     = valid_q;
  assign bus.o_Quotient  = result_q;
  assign bus.o_Flags     = flags_q;
  assign bus.o_Exception = exc_q;
endmodule

// File: tb/tb_divfp_iterative.sv
// Bench for divfp_iterative: directed cases, handshake hold, async abort, and random
// operands against an exact-integer division reference model.
module tb_divfp_iterative;
  localparam int unsigned EXP_W  = 5;
  localparam int unsigned MANT_W = 10;
  localparam int unsigned W      = 1 + EXP_W + MANT_W;
  localparam int unsigned QBITS  = MANT_W + 3;
  localparam int          BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam int          EMAXF  = (1 << EXP_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  divfp_iterative_if #(.EXP_W(EXP_W), .MANT_W(MANT_W)) bus ();

  divfp_iterative #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .bus       (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact rational quotient of the significands, rounded to nearest-even
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [3:0] fl,
                                  output int lat);
    int     ea, eb, e;
    longint fa, fb, ma, mb, num, s, r;
    logic   sgn, az, bz, ainf, binf, anan, bnan;
    ea = int'(a[W-2 -: EXP_W]);  eb = int'(b[W-2 -: EXP_W]);
    fa = longint'(a[MANT_W-1:0]); fb = longint'(b[MANT_W-1:0]);
    sgn  = a[W-1] ^ b[W-1];
    az   = (ea == 0);  bz = (eb == 0);
    ainf = (ea == EMAXF) && (fa == 0);  binf = (eb == EMAXF) && (fb == 0);
    anan = (ea == EMAXF) && (fa != 0);  bnan = (eb == EMAXF) && (fb != 0);
    lat = 1;
    if (anan || bnan || (az && bz) || (ainf && binf)) begin
      q = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}}; fl = 4'b1000;
    end else if (ainf) begin
      q = {sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}}; fl = 4'b0000;
    end else if (bz) begin
      q = {sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}}; fl = 4'b0100;
    end else if (az || binf) begin
      q = {sgn, {(W-1){1'b0}}}; fl = 4'b0000;
    end else begin
      lat = QBITS + 2;
      ma = (longint'(1) << MANT_W) + fa;
      mb = (longint'(1) << MANT_W) + fb;
      if (ma >= mb) begin
        e = ea - eb + BIAS;      num = ma << MANT_W;
      end else begin
        e = ea - eb + BIAS - 1;  num = ma << (MANT_W + 1);
      end
      s = num / mb;
      r = num % mb;
      if ((2 * r > mb) || ((2 * r == mb) && (s % 2 == 1))) s = s + 1;
      if (s == (longint'(1) << (MANT_W + 1))) begin
        s = s >> 1; e = e + 1;
      end
      if (e >= EMAXF) begin
        q = {sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}}; fl = 4'b0010;
      end else if (e <= 0) begin
        q = {sgn, {(W-1){1'b0}}}; fl = 4'b0001;
      end else begin
        q = {sgn, EXP_W'(e), MANT_W'(s)}; fl = 4'b0000;
      end
    end
  endfunction

  function automatic logic [W-1:0] gen_op();
    logic [W-1:0] v;
    v = W'($urandom);
    case ($urandom_range(0, 9))
      0: v[W-2 -: EXP_W] = '0;
      1: v[W-2 -: EXP_W] = '1;
      2: begin v[W-2 -: EXP_W] = '1; v[MANT_W-1:0] = '0; end
      3: v[W-2 -: EXP_W] = EXP_W'($urandom_range(EMAXF - 6, EMAXF - 1));
      4: v[W-2 -: EXP_W] = EXP_W'($urandom_range(1, 5));
      default: if (v[W-2 -: EXP_W] == '0 || v[W-2 -: EXP_W] == '1) v[W-2 -: EXP_W] = EXP_W'(BIAS);
    endcase
    return v;
  endfunction

  // Issue one operation and wait (bounded) for the result; lat counts from the accept edge
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [3:0] fl, output logic exc,
                        output int lat, output logic ready_low);
    @(negedge clk);
    bus.i_Dividend = a;
    bus.i_Divisor  = b;
    bus.i_Valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.i_Valid    = 1'b0;
    bus.i_Dividend = W'($urandom);
    bus.i_Divisor  = W'($urandom);
    lat = 1;
    ready_low = 1'b1;
    while (!bus.o_Valid && lat < 100) begin
      if (bus.o_Ready) ready_low = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.o_Ready) ready_low = 1'b0;
    q   = bus.o_Quotient;
    fl  = bus.o_Flags;
    exc = bus.o_Exception;
  endtask

  logic [W-1:0] dir_a [10] = '{16'h3C00, 16'h4600, 16'hC600, 16'h3C00, 16'h3C00,
                               16'h0000, 16'h7C00, 16'h7BFF, 16'h0400, 16'h0001};
  logic [W-1:0] dir_b [10] = '{16'h3C00, 16'h4000, 16'h4000, 16'h4200, 16'h0000,
                               16'h0000, 16'h4000, 16'h0400, 16'h7BFF, 16'h3C00};
  logic [W-1:0] dir_q [10] = '{16'h3C00, 16'h4200, 16'hC200, 16'h3555, 16'h7C00,
                               16'h7E00, 16'h7C00, 16'h7C00, 16'h0000, 16'h0000};
  logic [3:0]   dir_f [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100,
                               4'b1000, 4'b0000, 4'b0010, 4'b0001, 4'b0000};
  int           dir_l [10] = '{15, 15, 15, 15, 1, 1, 1, 15, 15, 1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q, eq, a, b;
    logic [3:0]   fl, efl;
    logic         exc, rdy_low, stable;
    int           lat, elat;

    bus.i_Valid    = 1'b0;
    bus.i_Ready    = 1'b1;
    bus.i_Dividend = '0;
    bus.i_Divisor  = '0;

    #12;
    check("reset_valid", 32'(bus.o_Valid), 32'h0);
    check("reset_quot",  32'(bus.o_Quotient), 32'h0);
    check("reset_flags", 32'(bus.o_Flags), 32'h0);
    check("reset_exc",   32'(bus.o_Exception), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(bus.o_Ready), 32'h1);

    for (int i = 0; i < 10; i++) begin
      run_op(dir_a[i], dir_b[i], q, fl, exc, lat, rdy_low);
      check($sformatf("dir%0d_quot", i), 32'(q), 32'(dir_q[i]));
      check($sformatf("dir%0d_flags", i), 32'(fl), 32'(dir_f[i]));
      check($sformatf("dir%0d_exc", i), 32'(exc), 32'(dir_f[i][3] | dir_f[i][2]));
      check($sformatf("dir%0d_latency", i), 32'(lat), 32'(dir_l[i]));
      check($sformatf("dir%0d_ready_low", i), 32'(rdy_low), 32'h1);
      @(posedge clk);
      #1;
      check($sformatf("dir%0d_handoff", i), 32'({bus.o_Valid, bus.o_Ready}), 32'b01);
    end

    // Back-pressure: result must hold and new requests must be ignored
    bus.i_Ready = 1'b0;
    run_op(16'h3C00, 16'h4200, q, fl, exc, lat, rdy_low);
    check("hold_first_quot", 32'(q), 32'h3555);
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.i_Valid    = 1'b1;
      bus.i_Dividend = gen_op();
      bus.i_Divisor  = gen_op();
      @(posedge clk);
      #1;
      if (bus.o_Quotient !== 16'h3555 || bus.o_Flags !== 4'b0000 ||
          bus.o_Ready !== 1'b0 || bus.o_Valid !== 1'b1) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'h1);
    @(negedge clk);
    bus.i_Valid = 1'b0;
    bus.i_Ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release", 32'({bus.o_Valid, bus.o_Ready}), 32'b01);
    @(posedge clk);
    #1;
    check("hold_single_handoff", 32'({bus.o_Valid, bus.o_Ready}), 32'b01);
    check("hold_quot_kept", 32'(bus.o_Quotient), 32'h3555);

    // Asynchronous abort in the middle of the divide
    @(negedge clk);
    bus.i_Dividend = 16'h3C00;
    bus.i_Divisor  = 16'h3C00;
    bus.i_Valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.i_Valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(bus.o_Valid), 32'h0);
    check("abort_ready", 32'(bus.o_Ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.o_Valid !== 1'b0) stable = 1'b0;
    end
    check("abort_no_result", 32'(stable), 32'h1);
    run_op(16'h4600, 16'h4000, q, fl, exc, lat, rdy_low);
    check("post_abort_quot", 32'(q), 32'h4200);
    check("post_abort_flags", 32'(fl), 32'h0);
    check("post_abort_latency", 32'(lat), 32'(QBITS + 2));
    @(posedge clk);
    #1;

    // Random operands against the reference model, with occasional back-pressure
    for (int i = 0; i < 300; i++) begin
      a = gen_op();
      b = gen_op();
      ref_div(a, b, eq, efl, elat);
      run_op(a, b, q, fl, exc, lat, rdy_low);
      check($sformatf("rnd%0d_quot %h/%h", i, a, b), 32'(q), 32'(eq));
      check($sformatf("rnd%0d_flags %h/%h", i, a, b), 32'(fl), 32'(efl));
      check($sformatf("rnd%0d_exc", i), 32'(exc), 32'(efl[3] | efl[2]));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
      check($sformatf("rnd%0d_ready_low", i), 32'(rdy_low), 32'h1);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.i_Ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        check($sformatf("rnd%0d_held", i), 32'({bus.o_Valid, bus.o_Quotient}), 32'({1'b1, eq}));
        bus.i_Ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_handoff", i), 32'({bus.o_Valid, bus.o_Ready}), 32'b01);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
